npe_requant: RTL and testbench
==============================

# npe_requant

Output stage directly downstream of the NPE core. It takes each full-precision NPE result beat (DATA_COPIES lanes of signed 2·DATA_WIDTH-bit values, delivered as a one-cycle valid pulse with no backpressure) and processes every lane by rounding right-shift, optional ReLU and saturation to signed DATA_WIDTH. It packs the lanes into one output word and buffers it in a small FIFO in front of a ready/valid write port to the output buffer. It counts accepted words per frame, pulses frame-done, and flags overflow because the NPE side cannot be stalled.

## Interface
- DATA_WIDTH, 8, output lane width; input lanes are 2·DATA_WIDTH bits
- DATA_COPIES, 32, lanes per beat
- FIFO_DEPTH, 4, output FIFO entries (power of two, ≥4)
- i_clk  in  1  clock; all logic on the rising edge
- i_rst  in  1  synchronous reset, active-high
- i_npe_result  in  DATA_COPIES·2·DATA_WIDTH  signed lanes; lane k is bits [k·16+15 : k·16]
- i_npe_result_vld  in  1  one-cycle beat strobe, no backpressure
- i_shift  in  4  right-shift amount 0..15, sampled with each beat
- i_relu_en  in  1  clamp negatives to 0, sampled with each beat
- i_frame_len  in  16  words per frame; 0 disables frame-done
- i_clr  in  1  synchronous soft clear
- o_wdata  out  DATA_COPIES·DATA_WIDTH  packed int8 lanes, lane k at [k·8+7 : k·8]
- o_wdata_vld  out  1  FIFO head valid
- i_wdata_rdy  in  1  consumer accepts when vld&rdy
- o_almost_full  out  1  FIFO count ≥ FIFO_DEPTH−2
- o_frame_done  out  1  one-cycle pulse
- o_overflow  out  1  sticky drop flag

## Operation
- Stage 1 registers each lane as r = (x + bias) >>> shift, computed in 17-bit signed. bias = 1<<(shift−1) when shift>0, else 0. The shift is arithmetic.
- Stage 2 applies ReLU (r<0 → 0 when i_relu_en), then saturates to [−128, 127], packs the lanes and writes the FIFO.
- Per-stage valid bits travel with the data. i_shift and i_relu_en are captured into stage 1 alongside the beat.
- FIFO is first-word-fall-through. o_wdata_vld = !empty and o_wdata = head.
- A word is accepted when o_wdata_vld & i_wdata_rdy.
- If stage 2 is valid while the FIFO is full and no pop happens in that cycle, the word is dropped and o_overflow is set.
- Full FIFO with a pop in the same cycle: push and pop both happen and nothing is dropped.
- Frame counter counts accepted words. When accepting the word that brings it to i_frame_len (non-zero), o_frame_done pulses on the next cycle and the counter returns to 0.
- i_clr empties the FIFO, invalidates both stages, zeroes the frame counter and clears o_overflow. A beat arriving in the same cycle as i_clr is discarded.
- i_rst does everything i_clr does. Reset values: o_wdata_vld=0, o_almost_full=0, o_frame_done=0, o_overflow=0, o_wdata=0.

## Timing
- Beat sampled at edge N → stage 1 valid after N → FIFO written at N+2 → o_wdata_vld high in the cycle after edge N+2 (latency 2 edges to visibility).
- Back-to-back beats sustain 1 word/cycle while i_wdata_rdy=1.
- o_almost_full leaves room for the 2 beats in flight. The NPE controller must stop issuing beats while it is high.
- Pop and count update happen on the accepting edge. o_frame_done is registered, one cycle after that edge.
- o_overflow rises on the edge of the drop and holds until i_clr or i_rst.

## Configuration
- NPE_REQUANT_ROUND_EN defined: bias added as above (round half up).
- Undefined: bias forced to 0 (truncating arithmetic shift) and the adder is removed. Latency is unchanged.

## Structure
- Shared package npe_pkg holds:
  - NPE_LANE_IN_W = 16, NPE_LANE_OUT_W = 8
  - NPE_SAT_MAX = 127, NPE_SAT_MIN = −128
  - the lane-extract index helper
- Sub-module npe_sync_fifo: parameterized width/depth, FWFT, same-cycle push/pop, count output, synchronous clear. Reusable by other NPE output paths.

## Test plan
- Lane 0 = 0x0180 (384), shift=4, relu=0 → lane 0 out 0x18 (24). 0x0188 (392) → 0x19 with round EN, 0x18 without.
- Lane = 0xFF00 (−256), shift=1 → 0x80 (−128 saturated). Same beat with relu=1 → 0x00. Lane 0x7FFF, shift=0 → 0x7F.
- 6 back-to-back beats with i_wdata_rdy=0 and FIFO_DEPTH=4 → 4 words held, o_almost_full high after the 2nd write, o_overflow set on the 5th arrival. Drain then shows the first 4 words in order.
- i_frame_len=3, 3 words accepted with rdy toggling 1,0,1,1 → o_frame_done single pulse the cycle after the 3rd accept, counter back to 0.
- FIFO full, beat arrives at stage 2 in the same cycle as a pop → no overflow and word order preserved.
- i_clr asserted with 2 words in the FIFO and a beat in flight → o_wdata_vld=0 the next cycle, no stale word ever appears, o_overflow=0.

Source files
------------

// File: rtl/npe_pkg.sv
// Shared constants and helpers for the NPE output paths (requant, sync FIFO users).
// Lane geometry and saturation bounds for the int16 -> int8 requant.
package npe_pkg;

  localparam int unsigned NPE_LANE_IN_W  = 16;
  localparam int unsigned NPE_LANE_OUT_W = 8;

  localparam int NPE_SAT_MAX = 127;
  localparam int NPE_SAT_MIN = -128;

  // Bit offset of lane `lane` inside a packed vector of `lane_w`-bit lanes.
  function automatic int unsigned npe_lane_lsb(input int unsigned lane,
                                               input int unsigned lane_w);
    return lane * lane_w;
  endfunction

endpackage

// File: rtl/npe_sync_fifo.sv
// First-word-fall-through synchronous FIFO with same-cycle push/pop and a soft clear.
// Depth must be a power of two so the pointers wrap naturally.
module npe_sync_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     clr_i,
  input  logic                     push_i,
  input  logic [Width-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [Width-1:0]         rdata_o,
  output logic                     empty_o,
  output logic                     full_o,
  output logic [$clog2(Depth):0]   count_o
);

  localparam int unsigned AddrW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [AddrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AddrW:0]   count_q;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AddrW + 1)'(Depth));
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // A full FIFO still takes a push when the head leaves on the same edge.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + (AddrW + 1)'(do_push) - (AddrW + 1)'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/npe_requant.sv
// NPE result requantiser: rounding shift, optional ReLU, int8 saturation, FWFT output FIFO.
// Define NPE_REQUANT_ROUND_EN for round-half-up; otherwise the shift truncates.
module npe_requant
  import npe_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = NPE_LANE_OUT_W,
  parameter int unsigned DATA_COPIES = 32,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic                                  i_clk,
  input  logic                                  i_rst,
  input  logic [DATA_COPIES*2*DATA_WIDTH-1:0]   i_npe_result,
  input  logic                                  i_npe_result_vld,
  input  logic [3:0]                            i_shift,
  input  logic                                  i_relu_en,
  input  logic [15:0]                           i_frame_len,
  input  logic                                  i_clr,
  output logic [DATA_COPIES*DATA_WIDTH-1:0]     o_wdata,
  output logic                                  o_wdata_vld,
  input  logic                                  i_wdata_rdy,
  output logic                                  o_almost_full,
  output logic                                  o_frame_done,
  output logic                                  o_overflow
);

  localparam int unsigned InW  = 2 * DATA_WIDTH;
  localparam int unsigned AccW = InW + 1;
  localparam int unsigned OutW = DATA_COPIES * DATA_WIDTH;
  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

  localparam logic signed [AccW-1:0] SatMax = AccW'(NPE_SAT_MAX);
  localparam logic signed [AccW-1:0] SatMin = AccW'(NPE_SAT_MIN);

  logic signed [AccW-1:0] s1_acc_d [DATA_COPIES];
  logic signed [AccW-1:0] s1_acc_q [DATA_COPIES];
  logic                   s1_vld_q, s1_relu_q;
  logic [OutW-1:0]        s2_word_d, s2_word_q;
  logic                   s2_vld_q;

  logic [OutW-1:0]        fifo_head;
  logic                   fifo_empty, fifo_full;
  logic [CntW-1:0]        fifo_count;
  logic                   accept, drop;

  logic [15:0]            frame_cnt_d, frame_cnt_q;
  logic                   frame_done_d, frame_done_q;
  logic                   overflow_d, overflow_q;

`ifdef NPE_REQUANT_ROUND_EN
  logic signed [AccW-1:0] bias;
  assign bias = (i_shift == 4'd0) ? '0 : (AccW'(1) << (i_shift - 4'd1));
`endif

  for (genvar k = 0; k < DATA_COPIES; k++) begin : g_lane
    localparam int unsigned InLsb  = npe_lane_lsb(k, InW);
    localparam int unsigned OutLsb = npe_lane_lsb(k, DATA_WIDTH);

    logic signed [AccW-1:0] ext;
    logic signed [AccW-1:0] pos;

    assign ext = {i_npe_result[InLsb+InW-1], i_npe_result[InLsb +: InW]};
`ifdef NPE_REQUANT_ROUND_EN
    assign s1_acc_d[k] = (ext + bias) >>> i_shift;
`else
    assign s1_acc_d[k] = ext >>> i_shift;
`endif

    assign pos = (s1_relu_q && s1_acc_q[k][AccW-1]) ? '0 : s1_acc_q[k];
    assign s2_word_d[OutLsb +: DATA_WIDTH] =
        (pos > SatMax) ? SatMax[DATA_WIDTH-1:0] :
        (pos < SatMin) ? SatMin[DATA_WIDTH-1:0] : pos[DATA_WIDTH-1:0];
  end

  // Valid bits honour clear/reset; the data registers only follow their valid.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      s1_vld_q <= 1'b0;
      s2_vld_q <= 1'b0;
    end else begin
      s1_vld_q <= i_npe_result_vld;
      s2_vld_q <= s1_vld_q;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_npe_result_vld) begin
      s1_acc_q  <= s1_acc_d;
      s1_relu_q <= i_relu_en;
    end
    if (s1_vld_q) s2_word_q <= s2_word_d;
  end

  npe_sync_fifo #(
    .Width (OutW),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (i_clk),
    .rst_i   (i_rst),
    .clr_i   (i_clr),
    .push_i  (s2_vld_q),
    .wdata_i (s2_word_q),
    .pop_i   (i_wdata_rdy),
    .rdata_o (fifo_head),
    .empty_o (fifo_empty),
    .full_o  (fifo_full),
    .count_o (fifo_count)
  );

  assign o_wdata_vld   = ~fifo_empty;
  assign o_wdata       = fifo_empty ? '0 : fifo_head;
  assign o_almost_full = (fifo_count >= CntW'(FIFO_DEPTH - 2));

  assign accept = o_wdata_vld & i_wdata_rdy;
  // The NPE cannot stall, so a word meeting a full FIFO with no pop is lost.
  assign drop   = s2_vld_q & fifo_full & ~accept;

  always_comb begin
    frame_cnt_d  = frame_cnt_q;
    frame_done_d = 1'b0;
    overflow_d   = overflow_q | drop;
    if (accept) begin
      if ((i_frame_len != 16'd0) && (frame_cnt_q + 16'd1 == i_frame_len)) begin
        frame_cnt_d  = '0;
        frame_done_d = 1'b1;
      end else begin
        frame_cnt_d = frame_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      frame_cnt_q  <= '0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      frame_cnt_q  <= frame_cnt_d;
      frame_done_q <= frame_done_d;
      overflow_q   <= overflow_d;
    end
  end

  assign o_frame_done = frame_done_q;
  assign o_overflow   = overflow_q;

endmodule

// File: tb/tb_npe_requant.sv
// Self-checking bench for npe_requant against a plain-arithmetic lane model.
// Expectations follow NPE_REQUANT_ROUND_EN when it is defined for the build.
module tb_npe_requant;

  localparam int DW = 8;
  localparam int DC = 32;
  localparam int IW = DC * 2 * DW;
  localparam int OW = DC * DW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [IW-1:0] npe_result = '0;
  logic          npe_vld = 1'b0;
  logic [3:0]    shift = '0;
  logic          relu = 1'b0;
  logic [15:0]   frame_len = '0;
  logic          clr = 1'b0;
  logic [OW-1:0] wdata;
  logic          wdata_vld;
  logic          wdata_rdy = 1'b0;
  logic          almost_full, frame_done, overflow;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  npe_requant dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_npe_result     (npe_result),
    .i_npe_result_vld (npe_vld),
    .i_shift          (shift),
    .i_relu_en        (relu),
    .i_frame_len      (frame_len),
    .i_clr            (clr),
    .o_wdata          (wdata),
    .o_wdata_vld      (wdata_vld),
    .i_wdata_rdy      (wdata_rdy),
    .o_almost_full    (almost_full),
    .o_frame_done     (frame_done),
    .o_overflow       (overflow)
  );

  // Reference: (x + bias) / 2^sh rounded toward -inf, then ReLU, then clamp to int8.
  function automatic logic [OW-1:0] model_word(input logic [IW-1:0] beat, input int sh,
                                                input bit rl);
    logic [OW-1:0] w;
    int x, r;
    w = '0;
    for (int k = 0; k < DC; k++) begin
      x = int'($signed(beat[k*16 +: 16]));
`ifdef NPE_REQUANT_ROUND_EN
      if (sh > 0) x = x + (1 << (sh - 1));
`endif
      r = x >>> sh;
      if (rl && r < 0) r = 0;
      if (r > 127) r = 127;
      if (r < -128) r = -128;
      w[k*8 +: 8] = r[7:0];
    end
    return w;
  endfunction

  function automatic logic [IW-1:0] rand_beat();
    logic [IW-1:0] b;
    logic [15:0] v;
    for (int k = 0; k < DC; k++) begin
      if ($urandom_range(0, 1) == 1) v = 16'($urandom);
      else v = 16'($urandom_range(0, 1023)) - 16'd512;
      b[k*16 +: 16] = v;
    end
    return b;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    npe_vld = 1'b0;
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    wdata_rdy = 1'b1;
    npe_result = rand_beat();
    npe_vld = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    npe_vld = 1'b0;
    n_cmp += 5;
    if (wdata_vld !== 1'b0) begin n_err++; $display("FAIL reset_vld got %b want 0", wdata_vld); end
    if (almost_full !== 1'b0) begin n_err++; $display("FAIL reset_af got %b want 0", almost_full); end
    if (frame_done !== 1'b0) begin n_err++; $display("FAIL reset_fd got %b want 0", frame_done); end
    if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_ov got %b want 0", overflow); end
    if (wdata !== '0) begin n_err++; $display("FAIL reset_wdata got %h want 0", wdata); end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (wdata_vld !== 1'b0) begin
        n_err++; $display("FAIL reset_beat_discard got vld %b want 0", wdata_vld);
      end
    end
  endtask

  task automatic test_directed_lanes();
    logic [15:0] lv [4];
    int          sv [4];
    bit          rv [4];
    logic [7:0]  ev [4];
    logic [7:0]  e1;
    logic [IW-1:0] b;
    lv = '{16'h0180, 16'hFF00, 16'hFF00, 16'h7FFF};
    sv = '{4, 1, 1, 0};
    rv = '{1'b0, 1'b0, 1'b1, 1'b0};
    ev = '{8'h18, 8'h80, 8'h00, 8'h7F};
`ifdef NPE_REQUANT_ROUND_EN
    e1 = 8'h19;
`else
    e1 = 8'h18;
`endif
    do_clear();
    wdata_rdy = 1'b1;
    for (int c = 0; c < 4; c++) begin
      b = rand_beat();
      b[15:0] = lv[c];
      b[31:16] = 16'h0188;
      npe_result = b;
      shift = 4'(sv[c]);
      relu = rv[c];
      npe_vld = 1'b1;
      tick();
      npe_vld = 1'b0;
      npe_result = rand_beat();
      shift = 4'($urandom_range(0, 15));
      relu = ~relu;
      n_cmp++;
      if (wdata_vld !== 1'b0) begin n_err++; $display("FAIL lat_e0 c%0d got 1 want 0", c); end
      tick();
      n_cmp++;
      if (wdata_vld !== 1'b0) begin n_err++; $display("FAIL lat_e1 c%0d got 1 want 0", c); end
      tick();
      n_cmp += 3;
      if (wdata_vld !== 1'b1) begin n_err++; $display("FAIL lat_e2 c%0d got 0 want 1", c); end
      if (wdata[7:0] !== ev[c]) begin
        n_err++; $display("FAIL lane0 c%0d got %h want %h", c, wdata[7:0], ev[c]);
      end
      if (wdata !== model_word(b, sv[c], rv[c])) begin
        n_err++; $display("FAIL word c%0d got %h want %h", c, wdata, model_word(b, sv[c], rv[c]));
      end
      if (c == 0) begin
        n_cmp++;
        if (wdata[15:8] !== e1) begin
          n_err++; $display("FAIL lane1_round got %h want %h", wdata[15:8], e1);
        end
      end
      tick();
    end
  endtask

  task automatic test_backpressure_overflow();
    logic [OW-1:0] w [6];
    logic [IW-1:0] b;
    int sh;
    bit rl;
    do_clear();
    wdata_rdy = 1'b0;
    for (int e = 1; e <= 9; e++) begin
      if (e <= 6) begin
        b = rand_beat();
        sh = $urandom_range(0, 15);
        rl = 1'($urandom_range(0, 1));
        w[e-1] = model_word(b, sh, rl);
        npe_result = b; shift = 4'(sh); relu = rl; npe_vld = 1'b1;
      end else begin
        npe_vld = 1'b0;
      end
      tick();
      if (e == 3) begin
        n_cmp++;
        if (almost_full !== 1'b0) begin n_err++; $display("FAIL af_after_w1 got 1 want 0"); end
      end
      if (e == 4) begin
        n_cmp++;
        if (almost_full !== 1'b1) begin n_err++; $display("FAIL af_after_w2 got 0 want 1"); end
      end
      if (e == 6) begin
        n_cmp++;
        if (overflow !== 1'b0) begin n_err++; $display("FAIL ov_before_drop got 1 want 0"); end
      end
      if (e == 7) begin
        n_cmp++;
        if (overflow !== 1'b1) begin n_err++; $display("FAIL ov_on_5th got 0 want 1"); end
      end
    end
    wdata_rdy = 1'b1;
    for (int j = 0; j < 4; j++) begin
      n_cmp += 2;
      if (wdata_vld !== 1'b1) begin n_err++; $display("FAIL bp_drain_vld%0d got 0 want 1", j); end
      if (wdata !== w[j]) begin
        n_err++; $display("FAIL bp_drain_word%0d got %h want %h", j, wdata, w[j]);
      end
      tick();
    end
    n_cmp += 2;
    if (wdata_vld !== 1'b0) begin n_err++; $display("FAIL bp_empty got 1 want 0"); end
    if (overflow !== 1'b1) begin n_err++; $display("FAIL ov_sticky got 0 want 1"); end
  endtask

  task automatic test_clear();
    n_cmp++;
    if (overflow !== 1'b1) begin n_err++; $display("FAIL clr_pre_ov got 0 want 1"); end
    wdata_rdy = 1'b0;
    for (int e = 1; e <= 5; e++) begin
      npe_result = rand_beat();
      shift = 4'($urandom_range(0, 15));
      npe_vld = 1'b1;
      clr = (e == 5);
      tick();
    end
    clr = 1'b0;
    npe_vld = 1'b0;
    n_cmp += 3;
    if (wdata_vld !== 1'b0) begin n_err++; $display("FAIL clr_vld got 1 want 0"); end
    if (overflow !== 1'b0) begin n_err++; $display("FAIL clr_ov got 1 want 0"); end
    if (almost_full !== 1'b0) begin n_err++; $display("FAIL clr_af got 1 want 0"); end
    wdata_rdy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      n_cmp++;
      if (wdata_vld !== 1'b0) begin n_err++; $display("FAIL clr_stale cyc%0d got 1 want 0", i); end
    end
  endtask

  task automatic test_frame_done();
    logic [OW-1:0] q [$];
    logic [IW-1:0] b;
    bit pat [6];
    int acc;
    bit pulse;
    pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    do_clear();
    frame_len = 16'd3;
    wdata_rdy = 1'b0;
    for (int e = 1; e <= 5; e++) begin
      if (e <= 3) begin
        b = rand_beat();
        npe_result = b; shift = 4'd3; relu = 1'b0; npe_vld = 1'b1;
        q.push_back(model_word(b, 3, 1'b0));
      end else begin
        npe_vld = 1'b0;
      end
      tick();
    end
    acc = 0;
    for (int p = 0; p < 6; p++) begin
      wdata_rdy = pat[p];
      pulse = 1'b0;
      n_cmp++;
      if (wdata_vld !== (q.size() > 0)) begin
        n_err++; $display("FAIL fr_vld p%0d got %b want %b", p, wdata_vld, q.size() > 0);
      end
      if (pat[p] && q.size() > 0) begin
        n_cmp++;
        if (wdata !== q[0]) begin
          n_err++; $display("FAIL fr_word p%0d got %h want %h", p, wdata, q[0]);
        end
        void'(q.pop_front());
        acc++;
        pulse = (acc == 3);
      end
      tick();
      n_cmp++;
      if (frame_done !== pulse) begin
        n_err++; $display("FAIL fr_done p%0d got %b want %b", p, frame_done, pulse);
      end
    end
    // Second frame with rdy held high: pulse only after its third word.
    wdata_rdy = 1'b1;
    for (int e = 1; e <= 9; e++) begin
      if (e <= 3) begin
        b = rand_beat();
        npe_result = b; shift = 4'd5; relu = 1'b1; npe_vld = 1'b1;
        q.push_back(model_word(b, 5, 1'b1));
      end else begin
        npe_vld = 1'b0;
      end
      n_cmp++;
      if (wdata_vld !== (e >= 4 && e <= 6)) begin
        n_err++; $display("FAIL fr2_vld e%0d got %b want %b", e, wdata_vld, e >= 4 && e <= 6);
      end
      if (e >= 4 && e <= 6 && q.size() > 0) begin
        n_cmp++;
        if (wdata !== q[0]) begin
          n_err++; $display("FAIL fr2_word e%0d got %h want %h", e, wdata, q[0]);
        end
        void'(q.pop_front());
      end
      tick();
      n_cmp++;
      if (frame_done !== (e == 6)) begin
        n_err++; $display("FAIL fr2_done e%0d got %b want %b", e, frame_done, e == 6);
      end
    end
    frame_len = 16'd0;
  endtask

  task automatic test_full_pop();
    logic [OW-1:0] w [5];
    logic [IW-1:0] b;
    do_clear();
    wdata_rdy = 1'b0;
    for (int e = 1; e <= 7; e++) begin
      if (e <= 5) begin
        b = rand_beat();
        npe_result = b; shift = 4'd2; relu = 1'b0; npe_vld = 1'b1;
        w[e-1] = model_word(b, 2, 1'b0);
      end else begin
        npe_vld = 1'b0;
      end
      wdata_rdy = (e == 7);
      if (e == 7) begin
        n_cmp += 2;
        if (wdata_vld !== 1'b1) begin n_err++; $display("FAIL fp_vld got 0 want 1"); end
        if (wdata !== w[0]) begin
          n_err++; $display("FAIL fp_word0 got %h want %h", wdata, w[0]);
        end
      end
      tick();
      if (e == 6) begin
        n_cmp++;
        if (almost_full !== 1'b1) begin n_err++; $display("FAIL fp_af got 0 want 1"); end
      end
    end
    n_cmp++;
    if (overflow !== 1'b0) begin n_err++; $display("FAIL fp_ov got 1 want 0"); end
    wdata_rdy = 1'b1;
    for (int j = 1; j < 5; j++) begin
      n_cmp += 2;
      if (wdata_vld !== 1'b1) begin n_err++; $display("FAIL fp_drain_vld%0d got 0 want 1", j); end
      if (wdata !== w[j]) begin
        n_err++; $display("FAIL fp_drain_word%0d got %h want %h", j, wdata, w[j]);
      end
      tick();
    end
    n_cmp += 2;
    if (wdata_vld !== 1'b0) begin n_err++; $display("FAIL fp_empty got 1 want 0"); end
    if (overflow !== 1'b0) begin n_err++; $display("FAIL fp_ov_end got 1 want 0"); end
  endtask

  task automatic test_back_to_back();
    logic [OW-1:0] w [8];
    logic [IW-1:0] b;
    int sh;
    do_clear();
    wdata_rdy = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      if (e <= 8) begin
        b = rand_beat();
        sh = $urandom_range(0, 15);
        npe_result = b; shift = 4'(sh); relu = 1'b0; npe_vld = 1'b1;
        w[e-1] = model_word(b, sh, 1'b0);
      end else begin
        npe_vld = 1'b0;
      end
      n_cmp++;
      if (wdata_vld !== (e >= 4 && e <= 11)) begin
        n_err++; $display("FAIL b2b_vld e%0d got %b want %b", e, wdata_vld, e >= 4 && e <= 11);
      end
      if (e >= 4 && e <= 11) begin
        n_cmp++;
        if (wdata !== w[e-4]) begin
          n_err++; $display("FAIL b2b_word e%0d got %h want %h", e, wdata, w[e-4]);
        end
      end
      tick();
    end
  endtask

  task automatic test_random_stream();
    logic [OW-1:0] q [$];
    logic [IW-1:0] b;
    int sh;
    bit rl;
    do_clear();
    frame_len = 16'd0;
    for (int c = 0; c < 400; c++) begin
      wdata_rdy = ($urandom_range(0, 3) != 0);
      if (c < 380 && almost_full == 1'b0 && $urandom_range(0, 2) != 0) begin
        b = rand_beat();
        sh = $urandom_range(0, 15);
        rl = 1'($urandom_range(0, 1));
        npe_result = b; shift = 4'(sh); relu = rl; npe_vld = 1'b1;
        q.push_back(model_word(b, sh, rl));
      end else begin
        npe_vld = 1'b0;
      end
      if (wdata_vld && wdata_rdy) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_err++; $display("FAIL rnd_extra cyc%0d got %h want none", c, wdata);
        end else begin
          if (wdata !== q[0]) begin
            n_err++; $display("FAIL rnd_word cyc%0d got %h want %h", c, wdata, q[0]);
          end
          void'(q.pop_front());
        end
      end
      tick();
      n_cmp++;
      if (frame_done !== 1'b0) begin n_err++; $display("FAIL rnd_fd cyc%0d got 1 want 0", c); end
    end
    npe_vld = 1'b0;
    wdata_rdy = 1'b1;
    for (int t = 0; t < 20 && q.size() > 0; t++) begin
      if (wdata_vld) begin
        n_cmp++;
        if (wdata !== q[0]) begin
          n_err++; $display("FAIL rnd_drain got %h want %h", wdata, q[0]);
        end
        void'(q.pop_front());
      end
      tick();
    end
    n_cmp += 3;
    if (q.size() != 0) begin n_err++; $display("FAIL rnd_left got %0d want 0", q.size()); end
    if (wdata_vld !== 1'b0) begin n_err++; $display("FAIL rnd_end_vld got 1 want 0"); end
    if (overflow !== 1'b0) begin n_err++; $display("FAIL rnd_ov got 1 want 0"); end
  endtask

  initial begin
    test_reset();
    test_directed_lanes();
    test_backpressure_overflow();
    test_clear();
    test_frame_done();
    test_full_pop();
    test_back_to_back();
    test_random_stream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
